// File: rtl/riscv_mem_arbiter.sv
// Round-robin 2:1 arbiter sharing one memory port between instruction and data requesters.
// Grant registered (request seen at N reaches memory at N+1); ready is combinational from mem_ready_i; a watchdog aborts stalled accesses.
module riscv_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid_i,
  output logic                    i_ready_o,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  input  logic [DATA_WIDTH-1:0]   i_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] i_we_i,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_valid_i,
  output logic                    d_ready_o,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_we_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_valid_o,
  input  logic                    mem_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o,
  output logic                    err_src_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state_q, state_d;
  logic          last_q;
  logic [CW-1:0] cnt_q;
  logic          err_src_q;
  logic          busy, serve_d, wdog_hit, done, grant, grant_d;

  assign busy     = (state_q != IDLE);
  assign serve_d  = (state_q == BUSY_D);
  assign wdog_hit = (TIMEOUT > 0) && busy && !mem_ready_i && (cnt_q == CNT_LAST);
  assign done     = busy && (mem_ready_i || wdog_hit);
  // A grant happens when leaving IDLE or when a completion hands over to the other port.
  assign grant    = (state_d != IDLE) && (!busy || done);
  assign grant_d  = (state_d == BUSY_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_valid_i && (!i_valid_i || !last_q)) begin
          state_d = BUSY_D;
        end else if (i_valid_i) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        if (done) begin
          state_d = d_valid_i ? BUSY_D : IDLE;
        end
      end
      BUSY_D: begin
        if (done) begin
          state_d = i_valid_i ? BUSY_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready_o = 1'b0;
    d_ready_o = 1'b0;
    i_rdata_o = '0;
    d_rdata_o = '0;
    err_o     = wdog_hit;
    if (done && !serve_d) begin
      i_ready_o = 1'b1;
      if (mem_ready_i) begin
        i_rdata_o = mem_rdata_i;
      end
    end
    if (done && serve_d) begin
      d_ready_o = 1'b1;
      if (mem_ready_i) begin
        d_rdata_o = mem_rdata_i;
      end
    end
  end

  // The abort source is visible in the abort cycle itself, then held.
  assign err_src_o = wdog_hit ? serve_d : err_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      err_src_q   <= 1'b0;
    end else begin
      if (grant) begin
        mem_valid_o <= 1'b1;
        mem_addr_o  <= grant_d ? d_addr_i : i_addr_i;
        mem_wdata_o <= grant_d ? d_wdata_i : i_wdata_i;
        mem_we_o    <= grant_d ? d_we_i : i_we_i;
        last_q      <= grant_d;
        cnt_q       <= '0;
      end else if (done) begin
        mem_valid_o <= 1'b0;
        cnt_q       <= '0;
      end else if (busy && !mem_ready_i && (TIMEOUT > 0)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (wdog_hit) begin
        err_src_q <= serve_d;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: vector table, directed corner sequences, then random traffic against a transaction-level model.
module tb_riscv_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid_i = 1'b0, d_valid_i = 1'b0, mem_ready_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
  logic [DW-1:0] i_wdata_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic [3:0]    i_we_i = '0, d_we_i = '0;
  logic          i_ready_o, d_ready_o, mem_valid_o, err_o, err_src_o;
  logic [DW-1:0] i_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_we_o;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
    .i_wdata_i(i_wdata_i), .i_we_i(i_we_i), .i_rdata_o(i_rdata_o),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_we_i(d_we_i), .d_rdata_o(d_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .err_src_o(err_src_o)
  );

  typedef struct packed {
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_we;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_we;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          err_src;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[9];

  function automatic in_t mkin(input logic iv, input logic [AW-1:0] ia, input logic dv,
                               input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                               input logic [3:0] dwe, input logic mr, input logic [DW-1:0] mrd);
    in_t r;
    r = {iv, ia, dv, da, dwd, dwe, mr, mrd};
    return r;
  endfunction

  function automatic out_t mk(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                              input logic [3:0] mwe, input logic ir, input logic [DW-1:0] ird,
                              input logic dr, input logic [DW-1:0] drd, input logic er,
                              input logic es);
    out_t r;
    r = {mv, ma, mwd, mwe, ir, ird, dr, drd, er, es};
    return r;
  endfunction

  task automatic drive(input in_t v);
    i_valid_i   = v.i_valid;
    i_addr_i    = v.i_addr;
    i_wdata_i   = '0;
    i_we_i      = '0;
    d_valid_i   = v.d_valid;
    d_addr_i    = v.d_addr;
    d_wdata_i   = v.d_wdata;
    d_we_i      = v.d_we;
    mem_ready_i = v.mem_ready;
    mem_rdata_i = v.mem_rdata;
  endtask

  // mem_addr/wdata/we are only meaningful while mem_valid_o is high.
  task automatic check(input string name, input out_t e);
    out_t a, x;
    x = e;
    a = {mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, i_ready_o, i_rdata_o,
         d_ready_o, d_rdata_o, err_o, err_src_o};
    if (!x.mem_valid) begin
      a.mem_addr = '0; a.mem_wdata = '0; a.mem_we = '0;
      x.mem_addr = '0; x.mem_wdata = '0; x.mem_we = '0;
    end
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, x);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one in-flight transaction and round-robin history.
  bit            m_act, m_port, m_last, m_esrc;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_we;
  bit            ip, dp;
  logic [AW-1:0] ia, da;
  logic [DW-1:0] iw, dw;
  logic [3:0]    ie, de;

  initial begin
    out_t zero;
    zero = '0;

    // Reset held with both ports requesting: everything stays quiet.
    drive(mkin(1, 'h1000, 1, 'hD000, 0, 0, 1, 'hABCD));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_hold", zero);
      next_cycle();
    end
    rst = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("post_reset_idle", zero);
    next_cycle();

    // Contention: D wins first, then strict alternation with no idle gap.
    for (int k = 0; k < 7; k++) begin
      drive(mkin(k != 6, AW'('h1000 + k / 2), 1, AW'('hD000 + (k + 1) / 2), 0, 0, 1, DW'('hA000 + k)));
      @(negedge clk);
      if (k % 2 == 0)
        check("contention_d", mk(1, AW'('hD000 + k / 2), 0, 0, 0, 0, 1, DW'('hA000 + k), 0, 0));
      else
        check("contention_i", mk(1, AW'('h1000 + k / 2), 0, 0, 1, DW'('hA000 + k), 0, 0, 0, 0));
      next_cycle();
    end
    drive(mkin(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("contention_drain", zero);
    next_cycle();

    // Single fetch, store passthrough with ignored idle ready, hand-over to I.
    tbl[0].in = mkin(1, 'h100, 0, 0, 0, 0, 0, 'h5555);
    tbl[0].exp = zero;
    tbl[1].in = mkin(1, 'h100, 0, 0, 0, 0, 1, 'hDEADBEEF);
    tbl[1].exp = mk(1, 'h100, 0, 0, 1, 'hDEADBEEF, 0, 0, 0, 0);
    tbl[2].in = mkin(0, 0, 0, 0, 0, 0, 0, 'h1);
    tbl[2].exp = zero;
    tbl[3].in = mkin(0, 0, 1, 'h2000, 'h12345678, 4'b0011, 1, 'h77);
    tbl[3].exp = zero;
    tbl[4].in = mkin(0, 0, 1, 'h2000, 'h12345678, 4'b0011, 0, 'h88);
    tbl[4].exp = mk(1, 'h2000, 'h12345678, 4'b0011, 0, 0, 0, 0, 0, 0);
    tbl[5].in = mkin(1, 'h300, 1, 'h2000, 'h12345678, 4'b0011, 1, 'hCAFEF00D);
    tbl[5].exp = mk(1, 'h2000, 'h12345678, 4'b0011, 0, 0, 1, 'hCAFEF00D, 0, 0);
    tbl[6].in = mkin(1, 'h300, 0, 0, 0, 0, 0, 'h99);
    tbl[6].exp = mk(1, 'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7].in = mkin(1, 'h300, 0, 0, 0, 0, 1, 'h11);
    tbl[7].exp = mk(1, 'h300, 0, 0, 1, 'h11, 0, 0, 0, 0);
    tbl[8].in = mkin(0, 0, 0, 0, 0, 0, 0, 'h22);
    tbl[8].exp = zero;
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].in);
      @(negedge clk);
      check($sformatf("table_row%0d", r), tbl[r].exp);
      next_cycle();
    end

    // Watchdog: data request, memory silent; abort in the 4th mem_valid cycle.
    drive(mkin(0, 0, 1, 'h40, 0, 0, 0, 'hFFFFFFFF));
    @(negedge clk);
    check("wdog_idle", zero);
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) check("wdog_wait", mk(1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0));
      else       check("wdog_abort", mk(1, 'h40, 0, 0, 0, 0, 1, 0, 1, 1));
      next_cycle();
    end
    drive(mkin(0, 0, 0, 0, 0, 0, 1, 'h1234));
    @(negedge clk);
    check("wdog_late_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    next_cycle();
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("wdog_err_src_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    next_cycle();

    // Asynchronous reset while BUSY_I.
    drive(mkin(1, 'h500, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("arst_req", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    next_cycle();
    @(negedge clk);
    check("arst_busy", mk(1, 'h500, 0, 0, 0, 0, 0, 0, 0, 1));
    #2 rst = 1'b1;
    #1 check("arst_drop", zero);
    next_cycle();
    rst = 1'b0;
    drive(mkin(1, 'h600, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("arst_release_idle", zero);
    next_cycle();
    drive(mkin(1, 'h600, 0, 0, 0, 0, 1, 'hBEEF));
    @(negedge clk);
    check("arst_regrant", mk(1, 'h600, 0, 0, 1, 'hBEEF, 0, 0, 0, 0));
    next_cycle();

    // Random traffic; model starts idle with I as the most recent grant.
    m_act = 0; m_last = 0; m_esrc = 0; m_age = 0; m_port = 0;
    ip = 0; dp = 0;
    for (int c = 0; c < 1500; c++) begin
      bit done, abrt, ci, cd, pick;
      out_t e;
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = $urandom; iw = $urandom; ie = 4'($urandom);
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; da = $urandom; dw = $urandom; de = 4'($urandom);
      end
      // The port currently being served may drop valid without cancelling.
      i_valid_i   = ip && !(m_act && m_port == 0 && $urandom_range(0, 3) == 0);
      d_valid_i   = dp && !(m_act && m_port == 1 && $urandom_range(0, 3) == 0);
      i_addr_i    = ia; i_wdata_i = iw; i_we_i = ie;
      d_addr_i    = da; d_wdata_i = dw; d_we_i = de;
      mem_ready_i = ($urandom_range(0, 4) < 2);
      mem_rdata_i = $urandom;

      done = m_act && (mem_ready_i || m_age == TO);
      abrt = m_act && !mem_ready_i && m_age == TO;
      e = mk(m_act, m_addr, m_wdata, m_we,
             done && !m_port, (done && !m_port && mem_ready_i) ? mem_rdata_i : '0,
             done && m_port, (done && m_port && mem_ready_i) ? mem_rdata_i : '0,
             abrt, abrt ? m_port : m_esrc);
      @(negedge clk);
      check("random", e);

      if (abrt) m_esrc = m_port;
      if (m_act && !done) begin
        m_age++;
      end else begin
        ci = i_valid_i && !(m_act && m_port == 0);
        cd = d_valid_i && !(m_act && m_port == 1);
        if (ci || cd) begin
          pick    = (ci && cd) ? !m_last : cd;
          m_act   = 1;
          m_port  = pick;
          m_last  = pick;
          m_age   = 1;
          m_addr  = pick ? d_addr_i : i_addr_i;
          m_wdata = pick ? d_wdata_i : i_wdata_i;
          m_we    = pick ? d_we_i : i_we_i;
        end else begin
          m_act = 0;
        end
      end
      if (done && !e.err_src && e.i_ready) ip = 0;
      if (e.i_ready) ip = 0;
      if (e.d_ready) dp = 0;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-to-one memory arbiter that shares a single unified memory port between the core's instruction-fetch port and its load/store port. The block sits between the core's imem/dmem valid/ready interfaces and one external memory. It is round-robin fair on contention and registers every granted transaction toward memory. A per-transaction watchdog aborts accesses that memory never acknowledges.

## Interface
- `ADDR_WIDTH`, default 32: address width of all ports.
- `DATA_WIDTH`, default 32: data width of all ports; the byte-enable width is `DATA_WIDTH/8`.
- `TIMEOUT`, default 256: maximum number of busy cycles before abort. A value of 0 disables the watchdog. The counter width is `$clog2(TIMEOUT+1)`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `i_valid_i`, in, 1: instruction-port request.
- `i_ready_o`, out, 1: one-cycle completion pulse for the instruction port.
- `i_addr_i`, in, `ADDR_WIDTH`: instruction-port address.
- `i_wdata_i`, in, `DATA_WIDTH`: instruction-port write data.
- `i_we_i`, in, `DATA_WIDTH/8`: instruction-port byte write enables.
- `i_rdata_o`, out, `DATA_WIDTH`: instruction-port read data, valid only with `i_ready_o`.
- `d_valid_i`, `d_ready_o`, `d_addr_i`, `d_wdata_i`, `d_we_i`, `d_rdata_o`: the same set of signals for the data port.
- `mem_valid_o`, out, 1: registered request to memory.
- `mem_ready_i`, in, 1: memory completion pulse.
- `mem_addr_o`, `mem_wdata_o`, `mem_we_o`: out, registered copies of the granted request.
- `mem_rdata_i`, in, `DATA_WIDTH`: memory read data.
- `err_o`, out, 1: one-cycle pulse on watchdog abort.
- `err_src_o`, out, 1: requester aborted (0 = instruction, 1 = data); holds its value until the next abort.

## Operation
- **Requester rule:** a requester holds `valid` high and its addr/wdata/we stable until it receives `ready`.
- **States:** IDLE, BUSY_I, BUSY_D. A `last` register records the most recent grant; it resets to instruction.
- **IDLE:**
  - Only one port is valid: grant that port.
  - Both ports are valid: grant the port that is not `last`.
  - The grant captures addr/wdata/we into the `mem_*` registers, sets `mem_valid_o`, updates `last`, and clears the watchdog counter.
- **BUSY_x with `mem_ready_i` high:**
  - `x_ready_o` is driven high combinationally in the same cycle.
  - `x_rdata_o` passes `mem_rdata_i` through.
- **Completion edge:**
  - The served port's `valid` is ignored at this edge, which prevents a double issue.
  - If the other port's `valid` is high, grant it directly: `mem_valid_o` stays high and the new address is loaded.
  - Otherwise go to IDLE and clear `mem_valid_o`.
- **Watchdog (`TIMEOUT` > 0):**
  - The counter increments on each BUSY cycle in which `mem_ready_i` is low.
  - In the BUSY cycle where the counter equals `TIMEOUT-1` and `mem_ready_i` is low:
    - `x_ready_o` = 1, `x_rdata_o` = 0, `err_o` = 1.
    - `err_src_o` is loaded with the aborted port.
    - That edge is then handled exactly like a completion edge.
- `mem_ready_i` sampled while `mem_valid_o` is low is ignored.
- A requester that drops `valid` mid-transaction does not cancel it. The memory access completes and the `ready` pulse is still issued.
- When no completion is occurring, `i_rdata_o` and `d_rdata_o` drive 0.

## Timing
- **Reset values:** every output is 0, including `mem_*` and `err_src_o`; state is IDLE and `last` is instruction. Assertion of `rst` mid-transaction drops `mem_valid_o` immediately and abandons the transaction.
- **Request to memory:** a request first seen in IDLE at cycle N drives `mem_valid_o` high from cycle N+1.
- **Completion:** `mem_ready_i` at cycle M produces `x_ready_o` at cycle M (zero added latency).
- **Contention:** a pending request on the other port is presented to memory from cycle M+1 with no idle gap. An uncontended new request arrives no earlier than M+1 and is presented at M+2.
- **Minimum access:** 2 cycles from requester `valid` to `ready`, when memory returns ready in the first cycle of `mem_valid_o`.
- **Abort timing:** an abort occurs exactly `TIMEOUT` cycles after `mem_valid_o` rises for that grant.

## Test plan
- **Reset:** hold `rst` high for 3 cycles with both ports valid. All outputs stay 0; after release, the first grant goes to data (`last` = instruction).
- **Single fetch:** `i_valid_i`=1, `i_addr_i`=0x100 at cycle 0; memory returns `mem_ready_i`=1 with rdata=0xDEADBEEF at cycle 1. Expect `mem_addr_o`=0x100 and `mem_valid_o`=1 at cycle 1, `i_ready_o`=1 and `i_rdata_o`=0xDEADBEEF at cycle 1, and `mem_valid_o`=0 at cycle 2.
- **Contention alternation:** both ports held valid continuously, memory ready one cycle after each request. Grants alternate D, I, D, I with `mem_valid_o` never dropping, and no port is served twice in a row.
- **Store passthrough:** `d_we_i`=4'b0011, `d_wdata_i`=0x12345678, `d_addr_i`=0x2000. Memory sees exactly these values registered, and `d_ready_o` pulses on `mem_ready_i`.
- **Watchdog:** `TIMEOUT`=4, memory never ready, data request. Expect `d_ready_o`=1, `d_rdata_o`=0, `err_o`=1, `err_src_o`=1 in the fourth `mem_valid_o` cycle; a late `mem_ready_i` in IDLE is ignored.
- **Async reset mid-transaction:** assert `rst` asynchronously during BUSY_I. `mem_valid_o` falls without a clock edge; after release, a new request is granted normally.
